proc_ctrl_pipe: RTL
===================

# proc_ctrl_pipe

Pipelined main control unit for the five-stage RV32I core. It decodes the ID-stage opcode into the standard control bundle and carries that bundle through ID/EX, EX/MEM and MEM/WB registers. It also owns load-use hazard detection, bubble insertion and branch/jump flush. An optional multi-cycle M-extension stall sequencer can be compiled in.

## Interface
- `RF_ADDR_W`, default 5: register-file address width.
- `MULDIV_LAT`, default 4: EX occupancy in cycles of a mul/div op (≥2). Only used with `CTRL_MULDIV_EN`.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all stage registers and the counter.
- `id_valid`  in  1  the IF/ID register holds a real instruction.
- `id_opcode`  in  7  opcode field of the ID instruction.
- `id_funct7`  in  7  funct7 field of the ID instruction.
- `id_rs1`, `id_rs2`, `id_rd`  in  RF_ADDR_W  each  register fields of the ID instruction.
- `flush`  in  1  redirect from EX (branch taken or jump resolved).
- `stall`  out  1  hold PC and IF/ID.
- `id_illegal`  out  1  `id_valid` with an undecodable opcode.
- `ex_ctrl`, `mem_ctrl`, `wb_ctrl`  out  12 each  control bundle per stage, `{ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp[1:0], Branch, JalrSel, RWSel[1:0]}`, plus `valid`, MSB first.
- `ex_rd`, `mem_rd`, `wb_rd`  out  RF_ADDR_W  each  destination register per stage.
- `ex_muldiv`  out  1  EX holds a mul/div op (constant 0 without the macro).

## Operation
- Decode, fields listed as ALUSrc/MemtoReg/RegWrite/MemRead/MemWrite/ALUOp/Branch/JalrSel/RWSel:
  - R 0110011: 0/0/1/0/0/10/0/0/00
  - I 0010011: 1/0/1/0/0/10/0/0/00
  - LOAD 0000011: 1/1/1/1/0/00/0/0/00
  - STORE 0100011: 1/0/0/0/1/00/0/0/00
  - BRANCH 1100011: 0/0/0/0/0/01/1/0/00
  - JAL 1101111: 0/0/1/0/0/11/1/0/01
  - JALR 1100111: 1/0/1/0/0/00/0/1/01
  - LUI 0110111: 0/0/1/0/0/11/0/0/10
  - AUIPC 0010111: 0/0/1/0/0/00/0/0/11
  - any other opcode: all zeros, `valid` = 0, `id_illegal` = 1.
- A bubble is the all-zero bundle with rd = 0.
- Load-use hazard:
  - Condition: `ex_ctrl.MemRead` and `ex_rd` ≠ 0 and `ex_rd` equals `id_rs1` or `id_rs2`, while `id_valid`.
  - Response: `stall` = 1 and a bubble enters EX.
- Flush: a bubble enters EX. The ID instruction is discarded because IF/ID is refilled by the fetch stage. `stall` is forced to 0.
- Priority, highest first: reset, flush, mul/div hold, load-use, normal advance.
- MEM and WB always advance: `mem <= ex`, `wb <= mem`. A held EX produces bubbles into MEM.

## Timing
- Reset: every `*_ctrl` and `*_rd` is 0, `stall` = 0, `ex_muldiv` = 0, counter = 0. `reset` asserted mid-operation aborts a mul/div sequence immediately.
- `stall` and `id_illegal` are combinational from the ID inputs and EX state, with no added latency.
- An instruction decoded in cycle N appears on `ex_*` at N+1, `mem_*` at N+2 and `wb_*` at N+3.
- A load-use stall lasts exactly 1 cycle; the dependent instruction reaches EX 2 cycles after the load.
- `flush` together with a load-use condition in the same cycle: only the flush takes effect; `stall` = 0.

## Configuration
- `CTRL_MULDIV_EN` defined:
  - Opcode 0110011 with funct7 0000001 decodes as R-type with `ex_muldiv` = 1 in EX.
  - On entry to EX the counter loads MULDIV_LAT−1.
  - While the counter is nonzero: `stall` = 1, EX holds its contents, MEM receives bubbles, and the counter decrements each cycle.
  - The op leaves EX when the counter reaches 0, giving total EX occupancy of MULDIV_LAT cycles.
  - `flush` clears the counter.
- `CTRL_MULDIV_EN` undefined: funct7 is ignored, no counter exists, and `ex_muldiv` is tied to 0.

## Structure
- Shared package `proc_pkg`: opcode localparams, the `ctrl_t` packed struct (12 bits), the `ALUOp` and `RWSel` enums, and the `CTRL_BUBBLE` constant.
- Sub-module `proc_ctrl_decode`: purely combinational opcode/funct7 to `ctrl_t`. It is the main decoder carried forward from the current core.
- Top module: stage registers, hazard logic and the mul/div counter.

## Test plan
- Reset, then the sequence ADD, LW, SW, BEQ, JAL, LUI, AUIPC → each bundle appears on `ex_ctrl` one cycle after ID with exactly the table values, then on `mem_ctrl` and `wb_ctrl` one and two cycles later.
- `lw x5` followed by `add x6,x5,x1` → `stall` = 1 for one cycle and a bubble on `ex_ctrl`; the ADD reaches EX 2 cycles after the LW. Repeat with the load targeting x0 → no stall.
- `flush` = 1 asserted while a load-use condition is present → `stall` = 0 and `ex_ctrl` is a bubble on the next cycle.
- Opcode 1111111 with `id_valid` → `id_illegal` = 1 and a bubble propagates through EX, MEM and WB.
- With `CTRL_MULDIV_EN` and MULDIV_LAT = 4, MUL followed by ADD → `stall` = 1 for 3 cycles, `ex_muldiv` high for 4 cycles, MEM receives 3 bubbles, then the ADD reaches EX.
- `reset` asserted on the second cycle of a mul/div hold → all outputs 0 immediately and the counter is 0 after reset is released.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared control-path types for the five-stage RV32I core: opcodes, control bundle, bubble constant.
package proc_pkg;

   localparam int unsigned OPCODE_W = 7;
   localparam int unsigned FUNCT7_W = 7;
   localparam int unsigned CTRL_W   = 12;

   localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
   localparam logic [OPCODE_W-1:0] OP_I      = 7'b0010011;
   localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
   localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
   localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
   localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;

   localparam logic [FUNCT7_W-1:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [1:0] {
      ALU_ADD  = 2'b00,
      ALU_BR   = 2'b01,
      ALU_FUNC = 2'b10,
      ALU_PASS = 2'b11
   } aluop_e;

   typedef enum logic [1:0] {
      RW_ALU   = 2'b00,
      RW_PC4   = 2'b01,
      RW_IMM   = 2'b10,
      RW_PCIMM = 2'b11
   } rwsel_e;

   typedef struct packed {
      logic   alusrc;
      logic   memtoreg;
      logic   regwrite;
      logic   memread;
      logic   memwrite;
      aluop_e aluop;
      logic   branch;
      logic   jalrsel;
      rwsel_e rwsel;
      logic   valid;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/proc_ctrl_decode.sv
// Main opcode decoder: opcode (and funct7 when CTRL_MULDIV_EN is defined) to control bundle.
module proc_ctrl_decode
   import proc_pkg::*;
(
   input  logic [OPCODE_W-1:0] opcode,
`ifdef CTRL_MULDIV_EN
   input  logic [FUNCT7_W-1:0] funct7,
   output logic                muldiv,
`endif
   output ctrl_t               ctrl
);

   always_comb begin
      ctrl       = CTRL_BUBBLE;
      ctrl.valid = 1'b1;
      case (opcode)
         OP_R: begin
            ctrl.regwrite = 1'b1;
            ctrl.aluop    = ALU_FUNC;
         end
         OP_I: begin
            ctrl.alusrc   = 1'b1;
            ctrl.regwrite = 1'b1;
            ctrl.aluop    = ALU_FUNC;
         end
         OP_LOAD: begin
            ctrl.alusrc   = 1'b1;
            ctrl.memtoreg = 1'b1;
            ctrl.regwrite = 1'b1;
            ctrl.memread  = 1'b1;
         end
         OP_STORE: begin
            ctrl.alusrc   = 1'b1;
            ctrl.memwrite = 1'b1;
         end
         OP_BRANCH: begin
            ctrl.aluop  = ALU_BR;
            ctrl.branch = 1'b1;
         end
         OP_JAL: begin
            ctrl.regwrite = 1'b1;
            ctrl.aluop    = ALU_PASS;
            ctrl.branch   = 1'b1;
            ctrl.rwsel    = RW_PC4;
         end
         OP_JALR: begin
            ctrl.alusrc   = 1'b1;
            ctrl.regwrite = 1'b1;
            ctrl.jalrsel  = 1'b1;
            ctrl.rwsel    = RW_PC4;
         end
         OP_LUI: begin
            ctrl.regwrite = 1'b1;
            ctrl.aluop    = ALU_PASS;
            ctrl.rwsel    = RW_IMM;
         end
         OP_AUIPC: begin
            ctrl.regwrite = 1'b1;
            ctrl.rwsel    = RW_PCIMM;
         end
         default: ctrl = CTRL_BUBBLE;
      endcase
   end

`ifdef CTRL_MULDIV_EN
   assign muldiv = (opcode == OP_R) && (funct7 == F7_MULDIV);
`endif

endmodule

// File: rtl/proc_ctrl_pipe.sv
// Pipelined main control: decode, ID/EX/MEM/WB control registers, load-use stall and flush.
// Optional multi-cycle mul/div EX hold compiled in with CTRL_MULDIV_EN.
module proc_ctrl_pipe
   import proc_pkg::*;
#(
   parameter int unsigned RF_ADDR_W  = 5,
   parameter int unsigned MULDIV_LAT = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 id_valid,
   input  logic [OPCODE_W-1:0]  id_opcode,
   input  logic [FUNCT7_W-1:0]  id_funct7,
   input  logic [RF_ADDR_W-1:0] id_rs1,
   input  logic [RF_ADDR_W-1:0] id_rs2,
   input  logic [RF_ADDR_W-1:0] id_rd,
   input  logic                 flush,
   output logic                 stall,
   output logic                 id_illegal,
   output ctrl_t                ex_ctrl,
   output ctrl_t                mem_ctrl,
   output ctrl_t                wb_ctrl,
   output logic [RF_ADDR_W-1:0] ex_rd,
   output logic [RF_ADDR_W-1:0] mem_rd,
   output logic [RF_ADDR_W-1:0] wb_rd,
   output logic                 ex_muldiv
);

   ctrl_t                dec_ctrl, id_ctrl, ex_ctrl_d, mem_ctrl_d;
   logic [RF_ADDR_W-1:0] id_rd_g, ex_rd_d, mem_rd_d;
   logic                 load_use, hold;

`ifdef CTRL_MULDIV_EN
   localparam int unsigned CNT_W = $clog2(MULDIV_LAT);
   logic             dec_muldiv, id_md, ex_md_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   proc_ctrl_decode u_decode (
      .opcode (id_opcode),
      .funct7 (id_funct7),
      .muldiv (dec_muldiv),
      .ctrl   (dec_ctrl)
   );

   assign id_md = id_valid && dec_muldiv;
   assign hold  = (cnt_q != '0);

   // Counter loads on mul/div entry to EX and counts the remaining hold cycles.
   always_comb begin
      cnt_d   = cnt_q;
      ex_md_d = ex_muldiv;
      if (flush) begin
         cnt_d   = '0;
         ex_md_d = 1'b0;
      end else if (hold) begin
         cnt_d = cnt_q - 1'b1;
      end else if (load_use) begin
         cnt_d   = '0;
         ex_md_d = 1'b0;
      end else begin
         ex_md_d = id_md;
         cnt_d   = id_md ? CNT_W'(MULDIV_LAT - 1) : '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q     <= '0;
         ex_muldiv <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         ex_muldiv <= ex_md_d;
      end
   end
`else
   logic unused_cfg;

   proc_ctrl_decode u_decode (
      .opcode (id_opcode),
      .ctrl   (dec_ctrl)
   );

   assign hold       = 1'b0;
   assign ex_muldiv  = 1'b0;
   assign unused_cfg = ^{id_funct7, 32'(MULDIV_LAT)};
`endif

   // Invalid or undecodable ID slots enter EX as bubbles.
   assign id_ctrl    = id_valid ? dec_ctrl : CTRL_BUBBLE;
   assign id_rd_g    = (id_valid && dec_ctrl.valid) ? id_rd : '0;
   assign id_illegal = id_valid && !dec_ctrl.valid;

   assign load_use = id_valid && ex_ctrl.memread && (ex_rd != '0) &&
                     ((ex_rd == id_rs1) || (ex_rd == id_rs2));
   assign stall    = !flush && (hold || load_use);

   // Priority: flush, mul/div hold, load-use bubble, normal advance.
   always_comb begin
      ex_ctrl_d  = id_ctrl;
      ex_rd_d    = id_rd_g;
      mem_ctrl_d = ex_ctrl;
      mem_rd_d   = ex_rd;
      if (flush) begin
         ex_ctrl_d = CTRL_BUBBLE;
         ex_rd_d   = '0;
      end else if (hold) begin
         ex_ctrl_d  = ex_ctrl;
         ex_rd_d    = ex_rd;
         mem_ctrl_d = CTRL_BUBBLE;
         mem_rd_d   = '0;
      end else if (load_use) begin
         ex_ctrl_d = CTRL_BUBBLE;
         ex_rd_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_ctrl  <= CTRL_BUBBLE;
         mem_ctrl <= CTRL_BUBBLE;
         wb_ctrl  <= CTRL_BUBBLE;
         ex_rd    <= '0;
         mem_rd   <= '0;
         wb_rd    <= '0;
      end else begin
         ex_ctrl  <= ex_ctrl_d;
         mem_ctrl <= mem_ctrl_d;
         wb_ctrl  <= mem_ctrl;
         ex_rd    <= ex_rd_d;
         mem_rd   <= mem_rd_d;
         wb_rd    <= mem_rd;
      end
   end

endmodule
